// File: rtl/mac_selftest_pkg.sv
// mac_selftest_pkg
//   Shared definitions for the MAC built-in self-test.
//   - state_t      : FSM state encoding
//   - LFSR_TAPS    : feedback mask for the 32-bit Fibonacci LFSR
//                    (x^32 + x^22 + x^2 + x + 1 -> bits 31, 21, 1, 0)
//   - DEFAULT_SEED : power-on LFSR seed
package mac_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_CMP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

endpackage

// File: rtl/mac_selftest_if.sv
// mac_selftest_if
//   Control/status bundle of the MAC self-test.
//   Ports (master = controller side, slave = mac_selftest):
//   - start      : one-cycle pulse, begins a run from IDLE or DONE
//   - inject_err : sampled in LOAD, flips bit 0 of that op's DSP product
//   - busy       : run in progress
//   - done       : run finished, held until next start or reset
//   - pass       : done with zero mismatches
//   - err_count  : saturating mismatch count of the current run
//   - ops_done   : operations compared so far in the current run
interface mac_selftest_if;

    logic        start;
    logic        inject_err;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] ops_done;

    modport master (
        output start,
        output inject_err,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  ops_done
    );

    modport slave (
        input  start,
        input  inject_err,
        output busy,
        output done,
        output pass,
        output err_count,
        output ops_done
    );

endinterface

// File: rtl/mac_pipe.sv
// mac_pipe
//   Registered unsigned a*b with PIPE register stages, shaped so yosys
//   can map it onto an SB_MAC16 (input regs, product reg, output reg).
//   The data path has no reset; the caller holds a/b stable until the
//   result has been consumed.
//   Ports:
//   - clk : system clock
//   - a   : multiplicand (WIDTH bits)
//   - b   : multiplier   (WIDTH bits)
//   - p   : product (2*WIDTH bits), valid PIPE cycles after a/b change
module mac_pipe #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input  logic                 clk,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p
);

    localparam logic [WIDTH-1:0] ZERO_W = '0;

    logic [2*WIDTH-1:0] prod_d;

    if (PIPE == 1) begin : g_pipe1
        logic [2*WIDTH-1:0] prod_q;

        always_comb prod_d = {ZERO_W, a} * {ZERO_W, b};

        always_ff @(posedge clk) begin
            prod_q <= prod_d;
        end

        assign p = prod_q;
    end else begin : g_pipen
        logic [WIDTH-1:0]   a_q;
        logic [WIDTH-1:0]   b_q;
        logic [2*WIDTH-1:0] prod_q;

        always_comb prod_d = {ZERO_W, a_q} * {ZERO_W, b_q};

        always_ff @(posedge clk) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= prod_d;
        end

        if (PIPE >= 3) begin : g_outreg
            logic [2*WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                out_q <= prod_q;
            end

            assign p = out_q;
        end else begin : g_noout
            assign p = prod_q;
        end
    end

endmodule

// File: rtl/mac_selftest.sv
// mac_selftest
//   Built-in self-test of the MAC path. LFSR operands feed a pipelined
//   DSP multiplier (mac_pipe) and a fabric shift-add reference; both
//   products are accumulated and the accumulators compared after every
//   op. Outputs come straight from flops/state, ready for LED drive.
//   Ports:
//   - clk : system clock
//   - rst : asynchronous active-high reset
//   - bus : mac_selftest_if.slave (start, inject_err in; busy, done,
//           pass, err_count, ops_done out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   LOAD  | latch a/b/inject_err, feed DSP path, clear reference, step LFSR
//   MUL   | WIDTH shift-add steps; DSP result settles and holds
//   CMP   | accumulate both products, compare, count
//   DONE  | run complete, results held until start
module mac_selftest
    import mac_selftest_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          ACC_WIDTH = 32,
    parameter int          NUM_OPS   = 256,
    parameter int          PIPE      = 2,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    mac_selftest_if.slave bus
);

    localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [15:0]     OPS_TARGET = 16'(NUM_OPS);
    // An all-zero Fibonacci LFSR would lock up.
    localparam logic [31:0]     SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [WIDTH-1:0] ZERO_W    = '0;

    state_t                 state_q,   state_d;
    logic [31:0]            lfsr_q,    lfsr_d;
    logic [WIDTH-1:0]       a_q,       a_d;
    logic [WIDTH-1:0]       b_q,       b_d;
    logic                   inj_q,     inj_d;
    logic [CW-1:0]          cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]     ref_q,     ref_d;
    logic [ACC_WIDTH-1:0]   acc_dsp_q, acc_dsp_d;
    logic [ACC_WIDTH-1:0]   acc_ref_q, acc_ref_d;
    logic [15:0]            err_q,     err_d;
    logic [15:0]            ops_q,     ops_d;

    logic                   lfsr_fb;
    logic [WIDTH-1:0]       dsp_a;
    logic [WIDTH-1:0]       dsp_b;
    logic [2*WIDTH-1:0]     dsp_p;
    logic [2*WIDTH-1:0]     dsp_prod;

    assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

    // Operands go to the DSP straight from the LFSR during LOAD, then from
    // the latched copies so the pipeline output stays put through CMP.
    assign dsp_a = (state_q == ST_LOAD) ? lfsr_q[WIDTH-1:0]       : a_q;
    assign dsp_b = (state_q == ST_LOAD) ? lfsr_q[2*WIDTH-1:WIDTH] : b_q;

    mac_pipe #(
        .WIDTH (WIDTH),
        .PIPE  (PIPE)
    ) u_mac_pipe (
        .clk (clk),
        .a   (dsp_a),
        .b   (dsp_b),
        .p   (dsp_p)
    );

    assign dsp_prod = dsp_p ^ {{(2*WIDTH-1){1'b0}}, inj_q};

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        a_d       = a_q;
        b_d       = b_q;
        inj_d     = inj_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        acc_dsp_d = acc_dsp_q;
        acc_ref_d = acc_ref_q;
        err_d     = err_q;
        ops_d     = ops_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_LOAD;
                    acc_dsp_d = '0;
                    acc_ref_d = '0;
                    err_d     = '0;
                    ops_d     = '0;
                end
            end
            ST_LOAD: begin
                a_d     = lfsr_q[WIDTH-1:0];
                b_d     = lfsr_q[2*WIDTH-1:WIDTH];
                inj_d   = bus.inject_err;
                ref_d   = '0;
                cnt_d   = '0;
                lfsr_d  = {lfsr_q[30:0], lfsr_fb};
                state_d = ST_MUL;
            end
            ST_MUL: begin
                if (a_q[cnt_q]) begin
                    ref_d = ref_q + ({ZERO_W, b_q} << cnt_q);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CMP: begin
                acc_dsp_d = acc_dsp_q + ACC_WIDTH'(dsp_prod);
                acc_ref_d = acc_ref_q + ACC_WIDTH'(ref_q);
                if ((acc_dsp_d != acc_ref_d) && (err_q != 16'hFFFF)) begin
                    err_d = err_q + 16'd1;
                end
                ops_d   = ops_q + 16'd1;
                state_d = (ops_d == OPS_TARGET) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED_EFF;
            a_q       <= '0;
            b_q       <= '0;
            inj_q     <= 1'b0;
            cnt_q     <= '0;
            ref_q     <= '0;
            acc_dsp_q <= '0;
            acc_ref_q <= '0;
            err_q     <= '0;
            ops_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            inj_q     <= inj_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            acc_dsp_q <= acc_dsp_d;
            acc_ref_q <= acc_ref_d;
            err_q     <= err_d;
            ops_q     <= ops_d;
        end
    end

    assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_MUL) || (state_q == ST_CMP);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (err_q == 16'd0);
    assign bus.err_count = err_q;
    assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_mac_selftest.sv
// tb_mac_selftest
//   Directed bench for mac_selftest. Four instances:
//   - dut_a : WIDTH 16, NUM_OPS 256, default seed (timing, restart, reset)
//   - dut_b : NUM_OPS 1, seed 0x0003_0005 (a=5, b=3, product 15)
//   - dut_c : NUM_OPS 20, error injected on op 10
//   - dut_d : WIDTH 4, PIPE 3, SEED 0, NUM_OPS 8 (seed substitution)
module tb_mac_selftest;

    logic clk;
    logic rst;
    logic rst_a;
    int   n_tests;
    int   n_fail;

    mac_selftest_if if_a ();
    mac_selftest_if if_b ();
    mac_selftest_if if_c ();
    mac_selftest_if if_d ();

    mac_selftest #(.WIDTH(16), .ACC_WIDTH(32), .NUM_OPS(256), .PIPE(2), .SEED(32'hACE1_0001))
        dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    mac_selftest #(.WIDTH(16), .ACC_WIDTH(32), .NUM_OPS(1), .PIPE(2), .SEED(32'h0003_0005))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    mac_selftest #(.WIDTH(16), .ACC_WIDTH(32), .NUM_OPS(20), .PIPE(1), .SEED(32'hACE1_0001))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    mac_selftest #(.WIDTH(4), .ACC_WIDTH(16), .NUM_OPS(8), .PIPE(3), .SEED(32'h0000_0000))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        n_tests++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
        n_tests++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
        n_tests++; if (if_a.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", if_a.pass); end
        n_tests++; if (if_a.err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", if_a.err_count); end
        n_tests++; if (if_a.ops_done !== 16'd0) begin n_fail++; $display("FAIL reset_ops: got %0d want 0", if_a.ops_done); end
        n_tests++; if (dut_a.lfsr_q !== 32'hACE1_0001) begin n_fail++; $display("FAIL reset_lfsr: got %h want ace10001", dut_a.lfsr_q); end
        n_tests++; if (dut_d.lfsr_q !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_seed0: got %h want 00000001", dut_d.lfsr_q); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rst_a = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", if_a.busy); end
    endtask

    task automatic test_single_op();
        int n;
        @(posedge clk); #1 if_b.start = 1'b1;
        @(posedge clk); #1 if_b.start = 1'b0;
        n = 0;
        while (if_b.done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        n_tests++; if (n != 18) begin n_fail++; $display("FAIL single_latency: got %0d want 18", n); end
        n_tests++; if (if_b.pass !== 1'b1) begin n_fail++; $display("FAIL single_pass: got %b want 1", if_b.pass); end
        n_tests++; if (if_b.ops_done !== 16'd1) begin n_fail++; $display("FAIL single_ops: got %0d want 1", if_b.ops_done); end
        n_tests++; if (dut_b.acc_ref_q !== 32'd15) begin n_fail++; $display("FAIL single_acc_ref: got %0d want 15", dut_b.acc_ref_q); end
        n_tests++; if (dut_b.acc_dsp_q !== 32'd15) begin n_fail++; $display("FAIL single_acc_dsp: got %0d want 15", dut_b.acc_dsp_q); end
        n_tests++; if (dut_b.lfsr_q !== 32'h0006_000B) begin n_fail++; $display("FAIL single_lfsr: got %h want 0006000b", dut_b.lfsr_q); end
    endtask

    task automatic test_full_run();
        int n;
        @(posedge clk); #1 if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
        n = 0;
        n_tests++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", if_a.busy); end
        repeat (18) begin @(posedge clk); n++; end
        #1;
        n_tests++; if (dut_a.acc_ref_q !== 32'h0000_ACE1) begin n_fail++; $display("FAIL full_first_acc: got %h want 0000ace1", dut_a.acc_ref_q); end
        n_tests++; if (if_a.ops_done !== 16'd1) begin n_fail++; $display("FAIL full_first_ops: got %0d want 1", if_a.ops_done); end
        while (if_a.done !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
        n_tests++; if (n != 4608) begin n_fail++; $display("FAIL full_latency: got %0d want 4608", n); end
        n_tests++; if (if_a.pass !== 1'b1) begin n_fail++; $display("FAIL full_pass: got %b want 1", if_a.pass); end
        n_tests++; if (if_a.err_count !== 16'd0) begin n_fail++; $display("FAIL full_err: got %0d want 0", if_a.err_count); end
        n_tests++; if (if_a.ops_done !== 16'd256) begin n_fail++; $display("FAIL full_ops: got %0d want 256", if_a.ops_done); end
        n_tests++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b want 0", if_a.busy); end
    endtask

    task automatic test_start_ignored();
        int n;
        if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
        n = 0;
        n_tests++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL rerun_done: got %b want 0", if_a.done); end
        n_tests++; if (if_a.ops_done !== 16'd0) begin n_fail++; $display("FAIL rerun_ops_clr: got %0d want 0", if_a.ops_done); end
        n_tests++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL rerun_busy: got %b want 1", if_a.busy); end
        repeat (18) begin @(posedge clk); n++; end
        #1;
        n_tests++; if (dut_a.acc_ref_q === 32'h0000_ACE1) begin n_fail++; $display("FAIL rerun_fresh_data: got %h want not 0000ace1", dut_a.acc_ref_q); end
        while (n < 50) begin @(posedge clk); n++; end
        #1 if_a.start = 1'b1;
        @(posedge clk); n++;
        #1 if_a.start = 1'b0;
        n_tests++; if (if_a.ops_done !== 16'd2) begin n_fail++; $display("FAIL busy_start_ops: got %0d want 2", if_a.ops_done); end
        while (n < 4607) begin @(posedge clk); n++; end
        #1 if_a.start = 1'b1;
        @(posedge clk); n++;
        #1 if_a.start = 1'b0;
        n_tests++; if (if_a.done !== 1'b1) begin n_fail++; $display("FAIL rerun_latency_done: got %b want 1", if_a.done); end
        n_tests++; if (if_a.pass !== 1'b1) begin n_fail++; $display("FAIL rerun_pass: got %b want 1", if_a.pass); end
        @(posedge clk); #1;
        n_tests++; if (if_a.done !== 1'b1 || if_a.busy !== 1'b0) begin n_fail++; $display("FAIL entry_start: got done=%b busy=%b want done=1 busy=0", if_a.done, if_a.busy); end
        n_tests++; if (if_a.ops_done !== 16'd256) begin n_fail++; $display("FAIL entry_start_ops: got %0d want 256", if_a.ops_done); end
    endtask

    task automatic test_reset_midrun();
        int n;
        if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
        n = 0;
        while (n < 93) begin @(posedge clk); n++; end
        #3;
        n_tests++; if (if_a.ops_done !== 16'd5) begin n_fail++; $display("FAIL mid_ops_pre: got %0d want 5", if_a.ops_done); end
        rst_a = 1'b1;
        #1;
        n_tests++; if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.pass !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got busy=%b done=%b pass=%b want 0 0 0", if_a.busy, if_a.done, if_a.pass); end
        n_tests++; if (if_a.ops_done !== 16'd0 || if_a.err_count !== 16'd0) begin n_fail++; $display("FAIL mid_counts: got ops=%0d err=%0d want 0 0", if_a.ops_done, if_a.err_count); end
        n_tests++; if (dut_a.lfsr_q !== 32'hACE1_0001 || dut_a.acc_dsp_q !== 32'd0) begin n_fail++; $display("FAIL mid_state: got lfsr=%h acc=%h want ace10001 0", dut_a.lfsr_q, dut_a.acc_dsp_q); end
        @(posedge clk); #1 rst_a = 1'b0;
        @(posedge clk); #1 if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
        n = 0;
        repeat (18) begin @(posedge clk); n++; end
        #1;
        n_tests++; if (dut_a.acc_dsp_q !== 32'h0000_ACE1) begin n_fail++; $display("FAIL mid_rerun_acc: got %h want 0000ace1", dut_a.acc_dsp_q); end
        while (if_a.done !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
        n_tests++; if (n != 4608 || if_a.pass !== 1'b1) begin n_fail++; $display("FAIL mid_rerun: got cycles=%0d pass=%b want 4608 1", n, if_a.pass); end
    endtask

    task automatic test_inject();
        int n;
        @(posedge clk); #1 if_c.start = 1'b1;
        @(posedge clk); #1 if_c.start = 1'b0;
        n = 0;
        while (n < 180) begin @(posedge clk); n++; end
        #1 if_c.inject_err = 1'b1;
        n_tests++; if (if_c.err_count !== 16'd0 || if_c.ops_done !== 16'd10) begin n_fail++; $display("FAIL inj_pre: got err=%0d ops=%0d want 0 10", if_c.err_count, if_c.ops_done); end
        @(posedge clk); n++;
        #1 if_c.inject_err = 1'b0;
        while (if_c.done !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        n_tests++; if (n != 360) begin n_fail++; $display("FAIL inj_latency: got %0d want 360", n); end
        n_tests++; if (if_c.err_count !== 16'd10) begin n_fail++; $display("FAIL inj_err: got %0d want 10", if_c.err_count); end
        n_tests++; if (if_c.pass !== 1'b0) begin n_fail++; $display("FAIL inj_pass: got %b want 0", if_c.pass); end
        n_tests++; if (if_c.ops_done !== 16'd20) begin n_fail++; $display("FAIL inj_ops: got %0d want 20", if_c.ops_done); end
    endtask

    task automatic test_seed_zero_w4();
        int n;
        @(posedge clk); #1 if_d.start = 1'b1;
        @(posedge clk); #1 if_d.start = 1'b0;
        n = 0;
        @(posedge clk); n++;
        #1;
        n_tests++; if (dut_d.lfsr_q !== 32'h0000_0003) begin n_fail++; $display("FAIL w4_lfsr_step: got %h want 00000003", dut_d.lfsr_q); end
        while (if_d.done !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
        n_tests++; if (n != 48) begin n_fail++; $display("FAIL w4_latency: got %0d want 48", n); end
        n_tests++; if (if_d.pass !== 1'b1 || if_d.ops_done !== 16'd8) begin n_fail++; $display("FAIL w4_result: got pass=%b ops=%0d want 1 8", if_d.pass, if_d.ops_done); end
        n_tests++; if (dut_d.acc_ref_q !== 16'd250) begin n_fail++; $display("FAIL w4_acc_ref: got %0d want 250", dut_d.acc_ref_q); end
        n_tests++; if (dut_d.acc_dsp_q !== 16'd250) begin n_fail++; $display("FAIL w4_acc_dsp: got %0d want 250", dut_d.acc_dsp_q); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rst_a   = 1'b1;
        if_a.start = 1'b0; if_a.inject_err = 1'b0;
        if_b.start = 1'b0; if_b.inject_err = 1'b0;
        if_c.start = 1'b0; if_c.inject_err = 1'b0;
        if_d.start = 1'b0; if_d.inject_err = 1'b0;

        test_reset();
        test_single_op();
        test_full_run();
        test_start_ignored();
        test_reset_midrun();
        test_inject();
        test_seed_zero_w4();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
